// File: rtl/act_mem_readout_if.sv
// act_mem_readout_if: control, activation-memory read port and output stream of the readout block.
interface act_mem_readout_if #(
    parameter int N_DIM_ARRAY              = 8,
    parameter int INPUT_CHANNEL_DATA_WIDTH = 8,
    parameter int INPUT_CHANNEL_ADDR_SIZE  = 16,
    parameter int BIT_WIDTH_EXTERNAL_PORT  = 32,
    parameter int LEN_BITS                 = 14
);
    localparam int RA_W = INPUT_CHANNEL_ADDR_SIZE - $clog2(N_DIM_ARRAY);
    logic                                      start;
    logic [INPUT_CHANNEL_ADDR_SIZE-1:0]        base_addr;
    logic [LEN_BITS-1:0]                       length_words;
    logic                                      mem_rd_en;
    logic [RA_W-1:0]                           mem_rd_addr;
    logic [N_DIM_ARRAY*INPUT_CHANNEL_DATA_WIDTH-1:0] mem_rd_data;
    logic                                      out_valid;
    logic                                      out_ready;
    logic [BIT_WIDTH_EXTERNAL_PORT-1:0]        out_data;
    logic                                      out_last;
    logic                                      busy;
    logic                                      done;
    modport master (
        input  start, base_addr, length_words, mem_rd_data, out_ready,
        output mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy, done
    );
    modport slave (
        output start, base_addr, length_words, mem_rd_data, out_ready,
        input  mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/act_mem_readout.sv
// act_mem_readout: fetches activation-memory rows into a 2-row buffer and streams them out as 32-bit words.
module act_mem_readout #(
    parameter int N_DIM_ARRAY              = 8,
    parameter int INPUT_CHANNEL_DATA_WIDTH = 8,
    parameter int INPUT_CHANNEL_ADDR_SIZE  = 16,
    parameter int BIT_WIDTH_EXTERNAL_PORT  = 32,
    parameter int LEN_BITS                 = 14
) (
    input logic             clk,
    input logic             reset,
    act_mem_readout_if.master bus
);
    localparam int ROW_LG = $clog2(N_DIM_ARRAY);
    localparam int WPR    = N_DIM_ARRAY / 4;
    localparam int LG     = $clog2(WPR);
    localparam int OW     = (WPR > 1) ? LG : 1;
    localparam int RA_W   = INPUT_CHANNEL_ADDR_SIZE - ROW_LG;
    localparam int RW     = N_DIM_ARRAY * INPUT_CHANNEL_DATA_WIDTH;
    localparam int CW     = LEN_BITS + 2;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [RA_W-1:0]     row_ptr_q;
    logic [LEN_BITS-1:0] rem_q;
    logic [CW-1:0]       rows_left_q;
    logic [OW-1:0]       next_ofs_q, pend_ofs_q;
    logic                pend_q;
    logic [1:0]          occ_q;
    logic                rd_ptr_q, wr_ptr_q;
    logic [RW-1:0]       data_q [2];
    logic [OW-1:0]       ofs_q  [2];

    logic [OW-1:0]       start_ofs, head_ofs;
    logic [CW-1:0]       span;
    logic                rd_issue, hs, pop;

    assign start_ofs = (WPR > 1) ? OW'(bus.base_addr >> 2) : '0;
    assign span      = CW'(start_ofs) + CW'(bus.length_words) + CW'(WPR - 1);
    assign head_ofs  = ofs_q[rd_ptr_q];

    // Reads are capped so buffered rows plus the one landing next edge never exceed two.
    assign rd_issue  = (state_q == RUN) && (rows_left_q != '0) && ((3'(occ_q) + 3'(pend_q)) < 3'd2);
    assign hs        = bus.out_valid && bus.out_ready;
    assign pop       = hs && ((head_ofs == OW'(WPR - 1)) || (rem_q == LEN_BITS'(1)));

    assign bus.mem_rd_en   = rd_issue;
    assign bus.mem_rd_addr = row_ptr_q;
    assign bus.out_valid   = (state_q == RUN) && (occ_q != 2'd0);
    assign bus.out_data    = bus.out_valid ? data_q[rd_ptr_q][32*head_ofs +: BIT_WIDTH_EXTERNAL_PORT] : '0;
    assign bus.out_last    = bus.out_valid && (rem_q == LEN_BITS'(1));
    assign bus.busy        = state_q != IDLE;
    assign bus.done        = state_q == FLUSH;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = !bus.start ? IDLE : (bus.length_words != '0) ? RUN : FLUSH;
            RUN:     state_d = (hs && bus.out_last) ? FLUSH : RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            row_ptr_q   <= '0;
            rem_q       <= '0;
            rows_left_q <= '0;
            next_ofs_q  <= '0;
            pend_ofs_q  <= '0;
            pend_q      <= 1'b0;
            occ_q       <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            data_q      <= '{default: '0};
            ofs_q       <= '{default: '0};
        end else begin
            state_q <= state_d;
            pend_q  <= rd_issue;
            occ_q   <= occ_q + 2'(pend_q) - 2'(pop);
            if (state_q == IDLE && bus.start) begin
                row_ptr_q   <= RA_W'(bus.base_addr >> ROW_LG);
                next_ofs_q  <= start_ofs;
                rem_q       <= bus.length_words;
                rows_left_q <= span >> LG;
            end
            if (rd_issue) begin
                row_ptr_q   <= row_ptr_q + 1'b1;
                rows_left_q <= rows_left_q - 1'b1;
                next_ofs_q  <= '0;
                pend_ofs_q  <= next_ofs_q;
            end
            if (pend_q) begin
                data_q[wr_ptr_q] <= bus.mem_rd_data;
                ofs_q[wr_ptr_q]  <= pend_ofs_q;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (hs) begin
                rem_q           <= rem_q - 1'b1;
                ofs_q[rd_ptr_q] <= head_ofs + 1'b1;
                rd_ptr_q        <= pop ? ~rd_ptr_q : rd_ptr_q;
            end
        end
    end
endmodule

// File: tb/tb_act_mem_readout.sv
// tb_act_mem_readout: directed tests of the activation-memory readout stream.
module tb_act_mem_readout;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    act_mem_readout_if bus ();
    act_mem_readout dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int s0 = 0;
    logic bp_mode = 1'b0;

    logic [12:0] rd_q[$];
    int          rd_cyc_q[$];
    logic [31:0] hs_q[$];
    logic        last_q[$];
    int          hs_cyc_q[$];
    int          done_q[$];
    int          valid_cnt = 0;
    int          stab_viol = 0;
    int          occ_viol = 0;
    logic        occ_en = 1'b0;
    int          occ_rb = 0, occ_hb = 0;
    logic        stall_q = 1'b0;
    logic [31:0] stall_data = '0;
    logic        stall_last = 1'b0;
    int          hb, rb, db, vb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] row_data(input logic [12:0] r);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'({r, 3'b000} + 16'(i));
        return d;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= row_data(bus.mem_rd_addr);

    always @(posedge clk) begin
        #1;
        bus.out_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (bus.mem_rd_en) begin
            rd_q.push_back(bus.mem_rd_addr);
            rd_cyc_q.push_back(cyc);
        end
        if (occ_en && ((rd_q.size() - occ_rb) - (hs_q.size() - occ_hb) / 2) > 2) occ_viol++;
        if (bus.out_valid) valid_cnt++;
        if (stall_q && (!bus.out_valid || bus.out_data != stall_data || bus.out_last != stall_last)) stab_viol++;
        stall_q    = bus.out_valid && !bus.out_ready;
        stall_data = bus.out_data;
        stall_last = bus.out_last;
        if (bus.out_valid && bus.out_ready) begin
            hs_q.push_back(bus.out_data);
            last_q.push_back(bus.out_last);
            hs_cyc_q.push_back(cyc);
        end
        if (bus.done) done_q.push_back(cyc);
    end

    task automatic snap();
        hb = hs_q.size(); rb = rd_q.size(); db = done_q.size(); vb = valid_cnt;
        occ_rb = rb; occ_hb = hb;
    endtask

    task automatic do_start(input logic [15:0] base, input logic [13:0] len);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = base; bus.length_words = len;
        @(posedge clk); #1;
        bus.start = 1'b0;
        s0 = cyc;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (bus.done) begin
                @(negedge clk);
                check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
                return;
            end
        end
        check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic check_stream(input string tag, input logic [31:0] e[$]);
        check({tag, "_nwords"}, 32'(hs_q.size() - hb), 32'(e.size()));
        for (int i = 0; i < e.size(); i++)
            if (hb + i < hs_q.size()) begin
                check($sformatf("%s_w%0d", tag, i), hs_q[hb+i], e[i]);
                check($sformatf("%s_last%0d", tag, i), 32'(last_q[hb+i]), 32'(i == e.size() - 1));
            end
    endtask

    task automatic check_reads(input string tag, input logic [12:0] e[$]);
        check({tag, "_nreads"}, 32'(rd_q.size() - rb), 32'(e.size()));
        for (int i = 0; i < e.size(); i++)
            if (rb + i < rd_q.size()) check($sformatf("%s_raddr%0d", tag, i), 32'(rd_q[rb+i]), 32'(e[i]));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"}, 32'(bus.mem_rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(bus.mem_rd_addr), 32'd0);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_data"}, bus.out_data, 32'd0);
        check({tag, "_last"}, 32'(bus.out_last), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.base_addr = '0; bus.length_words = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("rst");
        @(posedge clk); #1 reset = 1'b1;

        // aligned transfer with exact cycle timing
        snap(); occ_en = 1'b1;
        do_start(16'h0000, 14'd4);
        wait_done("t1", 50);
        occ_en = 1'b0;
        check_stream("t1", '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C});
        check_reads("t1", '{13'h0000, 13'h0001});
        if (hs_q.size() >= hb + 4) begin
            check("t1_first_cyc", 32'(hs_cyc_q[hb] - s0 + 1), 32'd3);
            check("t1_last_cyc", 32'(hs_cyc_q[hb+3] - s0 + 1), 32'd6);
        end
        if (rd_q.size() >= rb + 2) begin
            check("t1_rd0_cyc", 32'(rd_cyc_q[rb] - s0 + 1), 32'd1);
            check("t1_rd1_cyc", 32'(rd_cyc_q[rb+1] - s0 + 1), 32'd2);
        end
        if (done_q.size() > db) check("t1_done_cyc", 32'(done_q[db] - s0 + 1), 32'd7);

        // half-row start offset
        snap();
        do_start(16'h0004, 14'd3);
        wait_done("t2", 50);
        check_stream("t2", '{32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C});
        check_reads("t2", '{13'h0000, 13'h0001});

        // backpressure
        snap(); occ_en = 1'b1; bp_mode = 1'b1;
        do_start(16'h0000, 14'd6);
        wait_done("t3", 100);
        bp_mode = 1'b0; occ_en = 1'b0;
        check_stream("t3", '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 32'h13121110, 32'h17161514});
        check_reads("t3", '{13'h0000, 13'h0001, 13'h0002});
        check("t3_stable", 32'(stab_viol), 32'd0);
        check("t3_occupancy", 32'(occ_viol), 32'd0);

        // row-address wrap-around
        snap();
        do_start(16'hFFF8, 14'd4);
        wait_done("t4", 50);
        check_stream("t4", '{32'hFBFAF9F8, 32'hFFFEFDFC, 32'h03020100, 32'h07060504});
        check_reads("t4", '{13'h1FFF, 13'h0000});

        // zero length
        snap();
        do_start(16'h0010, 14'd0);
        wait_done("t5", 10);
        check("t5_reads", 32'(rd_q.size() - rb), 32'd0);
        check("t5_valid", 32'(valid_cnt - vb), 32'd0);
        if (done_q.size() > db) check("t5_done_cyc", 32'(done_q[db] - s0 + 1), 32'd1);

        // start while busy is ignored
        snap();
        do_start(16'h0000, 14'd4);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = 16'h0040; bus.length_words = 14'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("t6", 50);
        check_stream("t6", '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C});
        check_reads("t6", '{13'h0000, 13'h0001});
        check("t6_done_cnt", 32'(done_q.size() - db), 32'd1);

        // reset during the second word
        snap();
        do_start(16'h0000, 14'd8);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("t7");
        repeat (8) @(negedge clk);
        check("t7_no_done", 32'(done_q.size() - db), 32'd0);
        check("t7_words_before", 32'(hs_q.size() - hb), 32'd2);
        snap();
        do_start(16'h0000, 14'd1);
        wait_done("t7b", 50);
        check_stream("t7b", '{32'h03020100});
        check_reads("t7b", '{13'h0000});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
